pipelined_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter for the RV32I/RV64I execute path.
- Generalises the fixed 32-bit combinational logical right shifter:
  - selectable width;
  - SLL/SRL/SRA modes;
  - configurable number of register stages;
  - valid/ready handshake with full backpressure;
  - per-operation tag carried alongside the data.
- Sits between issue and writeback; tag returns with the result for register-file routing.

---
 rtl/pipelined_shifter.sv | 204 ++++++++++++++++++++
 tb/tb_pipelined_shifter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_shifter
//
// Parametrised, pipelined barrel shifter for the RV32I/RV64I execute path.
// Supports SLL, SRL and SRA, and optionally ROR. The SHAMT_W binary shift
// stages are split across PIPE_STAGES register groups. A valid/ready
// handshake with full backpressure moves the operations through the groups.
// A sideband tag travels with each operation so that writeback can route the
// result.
//
// Each register group captures an operation and then applies its own share of
// the shift stages combinationally on the way to the next group. The output
// is taken from the last group. The result therefore appears PIPE_STAGES
// cycles after acceptance.
//
// SLL runs on the same right-shift network. The operand is bit-reversed on
// entry and the result is bit-reversed on exit.
//
// Configuration macro:
//   SHIFTER_ROTATE_EN  defined   : i_op=11 is rotate right (ROR/RORI)
//                      undefined : i_op=11 behaves exactly like SRL
//
// Ports:
//   i_clk    in   1        clock, rising edge
//   i_rst    in   1        asynchronous active-high reset
//   i_valid  in   1        input operation valid
//   o_ready  out  1        shifter can accept an operation this cycle
//   i_a      in   XLEN     operand to shift
//   i_b      in   SHAMT_W  shift amount
//   i_op     in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR/SRL
//   i_tag    in   TAG_W    sideband tag
//   o_valid  out  1        result valid
//   i_ready  in   1        downstream accepts result
//   o_data   out  XLEN     shifted result
//   o_tag    out  TAG_W    tag of the operation in o_data
// -----------------------------------------------------------------------------
module pipelined_shifter #(
   parameter int XLEN        = 32,
   parameter int SHAMT_W     = $clog2(XLEN),
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [XLEN-1:0]    i_a,
   input  logic [SHAMT_W-1:0] i_b,
   input  logic [1:0]         i_op,
   input  logic [TAG_W-1:0]   i_tag,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [XLEN-1:0]    o_data,
   output logic [TAG_W-1:0]   o_tag
);

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   // One register group's payload. The sign of i_a is captured on entry so
   // that SRA fill is still correct after partial shifting.
   typedef struct packed {
      logic [XLEN-1:0]    data;
      logic [SHAMT_W-1:0] shamt;
      op_e                op;
      logic [TAG_W-1:0]   tag;
      logic               fill;
   } slot_t;

   // Split the stages as evenly as possible. The earlier groups take the
   // leftover stages.
   localparam int BASE = SHAMT_W / PIPE_STAGES;
   localparam int REM  = SHAMT_W % PIPE_STAGES;

   function automatic int grp_lo(input int g);
      return g * BASE + ((g < REM) ? g : REM);
   endfunction

   function automatic int grp_hi(input int g);
      return grp_lo(g) + BASE + ((g < REM) ? 1 : 0);
   endfunction

   function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] x);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
      return r;
   endfunction

   // Apply binary stages lo..hi-1. Stage k moves the data right by 2^k when
   // amt[k] is set.
   function automatic logic [XLEN-1:0] shift_range(
      input logic [XLEN-1:0]    x,
      input logic [SHAMT_W-1:0] amt,
      input op_e                op,
      input logic               fill,
      input int                 lo,
      input int                 hi
   );
      logic [XLEN-1:0] r;
      logic [XLEN-1:0] shifted;
      logic [XLEN-1:0] top_mask;
      int              sh;
      r = x;
      for (int k = 0; k < SHAMT_W; k++) begin
         if (k >= lo && k < hi && amt[k]) begin
            sh       = 1 << k;
            shifted  = r >> sh;
            top_mask = ~({XLEN{1'b1}} >> sh);
`ifdef SHIFTER_ROTATE_EN
            if (op == OP_ROR)
               r = shifted | (r << (XLEN - sh));
            else if (op == OP_SRA && fill)
               r = shifted | top_mask;
            else
               r = shifted;
`else
            if (op == OP_SRA && fill)
               r = shifted | top_mask;
            else
               r = shifted;
`endif
         end
      end
      return r;
   endfunction

   logic  [PIPE_STAGES-1:0]            valid_q;
   slot_t [PIPE_STAGES-1:0]            slot_q;
   logic  [PIPE_STAGES-1:0]            ready;
   logic  [PIPE_STAGES-1:0]            up_valid;
   slot_t [PIPE_STAGES-1:0]            up_slot;
   logic  [PIPE_STAGES-1:0][XLEN-1:0]  grp_out;

   // Ready chain from the output back to the input. A group may load when it
   // is empty or when the group after it is also able to move. A stall at the
   // output therefore never blocks an upstream bubble from filling.
   always_comb begin
      logic r;
      // NOTE: every combinational output gets a default before the loop, so
      // no path can leave a value unassigned and infer a latch.
      ready = '0;
      r     = i_ready;
      for (int g = PIPE_STAGES - 1; g >= 0; g--) begin
         r        = !valid_q[g] || r;
         ready[g] = r;
      end
   end

   // Shift work done by each group on the operation it currently holds.
   always_comb begin
      grp_out = '0;
      for (int g = 0; g < PIPE_STAGES; g++)
         grp_out[g] = shift_range(slot_q[g].data, slot_q[g].shamt, slot_q[g].op,
                                  slot_q[g].fill, grp_lo(g), grp_hi(g));
   end

   // Candidate payload for each group: the new operation for group 0, and the
   // partially shifted payload of the previous group for every later group.
   always_comb begin
      up_valid         = '0;
      up_slot          = '0;
      up_valid[0]      = i_valid;
      up_slot[0].data  = (op_e'(i_op) == OP_SLL) ? bit_rev(i_a) : i_a;
      up_slot[0].shamt = i_b;
      up_slot[0].op    = op_e'(i_op);
      up_slot[0].tag   = i_tag;
      up_slot[0].fill  = i_a[XLEN-1];
      for (int g = 1; g < PIPE_STAGES; g++) begin
         up_valid[g]     = valid_q[g-1];
         up_slot[g]      = slot_q[g-1];
         up_slot[g].data = grp_out[g-1];
      end
   end

   // NOTE: state is written with non-blocking assignments, so every group
   // samples its upstream neighbour's value from before this clock edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= '0;
         // NOTE: the payload is cleared as well as the valid bits, so that
         // o_data and o_tag read as zero until the first result leaves.
         slot_q  <= '0;
      end else begin
         for (int g = 0; g < PIPE_STAGES; g++) begin
            if (ready[g]) begin
               valid_q[g] <= up_valid[g];
               // The payload holds its last value when the slot empties.
               if (up_valid[g]) slot_q[g] <= up_slot[g];
            end
         end
      end
   end

   assign o_ready = ready[0];
   assign o_valid = valid_q[PIPE_STAGES-1];
   assign o_tag   = slot_q[PIPE_STAGES-1].tag;
   assign o_data  = (slot_q[PIPE_STAGES-1].op == OP_SLL) ? bit_rev(grp_out[PIPE_STAGES-1])
                                                          : grp_out[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_shifter
//
// Self-checking bench for pipelined_shifter with XLEN=32 and PIPE_STAGES=2.
// Inputs are driven 1 time unit after the rising edge. A monitor samples on
// the falling edge. Expected results come from a table of constants or from
// an arithmetic reference model, and a queue tracks operations in flight.
// -----------------------------------------------------------------------------
module tb_pipelined_shifter;

   localparam int XLEN        = 32;
   localparam int SHAMT_W     = 5;
   localparam int PIPE_STAGES = 2;
   localparam int TAG_W       = 5;

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_valid = 1'b0;
   logic               o_ready;
   logic [XLEN-1:0]    i_a = '0;
   logic [SHAMT_W-1:0] i_b = '0;
   logic [1:0]         i_op = '0;
   logic [TAG_W-1:0]   i_tag = '0;
   logic               o_valid;
   logic               i_ready = 1'b1;
   logic [XLEN-1:0]    o_data;
   logic [TAG_W-1:0]   o_tag;

   pipelined_shifter #(
      .XLEN(XLEN), .PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_tag(i_tag),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the shift rules written as plain operators.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] b,
                                         input logic [1:0] op);
      logic signed [31:0] s;
      s = a;
      case (op)
         2'b00: return a << b;
         2'b01: return a >> b;
         2'b10: return s >>> b;
         default: begin
`ifdef SHIFTER_ROTATE_EN
            return (a >> b) | (a << (32 - int'(b)));
`else
            return a >> b;
`endif
         end
      endcase
   endfunction

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        q[$];
   logic [31:0] cur_exp = '0;
   bit          lat_chk = 1'b0;
   bit          mon_en  = 1'b0;

   // Monitor: checks ready, output hold, in-order results and latency.
   initial begin
      bit          stall_prev;
      logic [31:0] prev_data;
      logic [4:0]  prev_tag;
      exp_t        e;
      stall_prev = 1'b0;
      prev_data  = '0;
      prev_tag   = '0;
      forever begin
         @(negedge i_clk);
         if (mon_en && !i_rst) begin
            check("o_ready", o_ready, (q.size() < PIPE_STAGES) || i_ready);
            if (stall_prev) begin
               check("hold_valid", o_valid, 1'b1);
               check("hold_data", o_data, prev_data);
               check("hold_tag", o_tag, prev_tag);
            end
            if (o_valid && i_ready) begin
               if (q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL stray_result: got data %0h tag %0h, expected no result (t=%0t)",
                           o_data, o_tag, $time);
               end else begin
                  e = q.pop_front();
                  check("data", o_data, e.data);
                  check("tag", o_tag, e.tag);
                  if (e.lat) check("latency", cyc - e.acc, PIPE_STAGES);
               end
            end
            stall_prev = o_valid && !i_ready;
            prev_data  = o_data;
            prev_tag   = o_tag;
            if (i_valid && o_ready) q.push_back('{cur_exp, i_tag, cyc, lat_chk});
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   // Present one operation and hold it until accepted. Returns on the falling
   // edge just before the accepting rising edge.
   task automatic send(input logic [31:0] a, input logic [4:0] b, input logic [1:0] op,
                       input logic [4:0] tag, input logic [31:0] exp);
      @(posedge i_clk);
      #1;
      i_valid = 1'b1;
      i_a     = a;
      i_b     = b;
      i_op    = op;
      i_tag   = tag;
      cur_exp = exp;
      for (int n = 0; n < 100; n++) begin
         @(negedge i_clk);
         if (o_ready) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got o_ready=0 for 100 cycles, expected acceptance");
   endtask

   task automatic idle();
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 60 && q.size() != 0; n++) @(negedge i_clk);
      check("drain_empty", q.size(), 0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [4:0]  b;
      logic [1:0]  op;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[12];

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      bit done;
      vt[0]  = '{32'h8000_00F0, 5'd4,  2'b01, 32'h0800_000F};
      vt[1]  = '{32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F};
      vt[2]  = '{32'h8000_00F0, 5'd4,  2'b00, 32'h0000_0F00};
      vt[3]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF};
      vt[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF};
      vt[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF};
      vt[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF};
      vt[7]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
      vt[8]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
      vt[9]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};
`ifdef SHIFTER_ROTATE_EN
      vt[10] = '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000};
`else
      vt[10] = '{32'h0000_0001, 5'd1,  2'b11, 32'h0000_0000};
`endif
      vt[11] = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};

      // Values during and after the initial reset.
      #3;
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_o_data", o_data, '0);
      check("rst_o_tag", o_tag, '0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("post_rst_o_ready", o_ready, 1'b1);
      check("post_rst_o_data", o_data, '0);
      mon_en = 1'b1;

      // Table vectors, one at a time, with the latency checked.
      lat_chk = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send(vt[i].a, vt[i].b, vt[i].op, 5'(i + 16), vt[i].exp);
         idle();
         drain();
      end

      // Back-to-back stream of 8 ops: results on consecutive cycles, in order.
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a;
         a = $urandom;
         send(a, 5'(i * 3), 2'(i), 5'(i), model(a, 5'(i * 3), 2'(i)));
      end
      idle();
      drain();

      // The same stream with i_ready held low for 4 cycles mid-stream.
      lat_chk = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [31:0] a;
               a = $urandom;
               send(a, 5'(i + 1), 2'(i), 5'(i), model(a, 5'(i + 1), 2'(i)));
            end
            idle();
         end
         begin
            repeat (3) @(posedge i_clk);
            #1;
            i_ready = 1'b0;
            repeat (4) @(posedge i_clk);
            #1;
            i_ready = 1'b1;
         end
      join
      drain();

      // Asynchronous reset with two operations in flight.
      send(32'h1234_5678, 5'd3, 2'b01, 5'd9, model(32'h1234_5678, 5'd3, 2'b01));
      send(32'h8765_4321, 5'd7, 2'b10, 5'd10, model(32'h8765_4321, 5'd7, 2'b10));
      @(posedge i_clk);
      #2;
      i_valid = 1'b0;
      check("inflight_o_valid", o_valid, 1'b1);
      i_rst = 1'b1;
      #1;
      check("async_rst_o_valid", o_valid, 1'b0);
      check("async_rst_o_data", o_data, '0);
      check("async_rst_o_tag", o_tag, '0);
      q.delete();
      repeat (2) @(posedge i_clk);
      #2;
      i_rst = 1'b0;
      @(negedge i_clk);
      check("rerst_o_ready", o_ready, 1'b1);
      check("rerst_o_valid", o_valid, 1'b0);
      repeat (6) @(negedge i_clk);
      check("rerst_o_data", o_data, '0);

      // Random operations with random gaps and random backpressure.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               logic [31:0] a;
               logic [4:0]  b;
               logic [1:0]  op;
               a  = $urandom;
               b  = 5'($urandom_range(0, 31));
               op = 2'($urandom_range(0, 3));
               if ($urandom_range(0, 3) == 0) idle();
               send(a, b, op, 5'($urandom), model(a, b, op));
            end
            idle();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge i_clk);
               #1;
               i_ready = ($urandom_range(0, 3) != 0);
            end
            i_ready = 1'b1;
         end
      join
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
